// File: rtl/mult_booth_ctrl.sv
// Sequencer for the radix-4 Booth step unit: latches operands, steers the step
// unit's feedback for 16 iterations, then presents result, overflow and ready.
module mult_booth_ctrl #(
    parameter int N_STEPS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [64:0] step_product,
    output logic [64:0] step_prev_product,
    output logic [31:0] step_multiplicand,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic [31:0] fin_result;
    logic        fin_exc;

    // Product bits [64:1] are the 64-bit signed product; overflow means the
    // upper word is not a pure sign extension of the low word.
    assign fin_result = step_product[32:1];
    assign fin_exc    = (step_product[64:33] != {32{step_product[32]}});

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            // The finishing op always commits its result, even when a new start aborts nothing.
            if (state == DONE) begin
                result_q <= fin_result;
                exc_q    <= fin_exc;
            end
            if (ctrl_MULT) begin
                mcand_q  <= data_operandA;
                mplier_q <= data_operandB;
                count    <= 5'd0;
                state    <= LOAD;
            end else begin
                case (state)
                    LOAD: begin
                        count <= 5'd1;
                        state <= RUN;
                    end
                    RUN: begin
                        count <= count + 5'd1;
                        if (count == 5'(N_STEPS - 1)) state <= DONE;
                    end
                    DONE: begin
                        count <= 5'd0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        step_prev_product = 65'd0;
        case (state)
            LOAD:    step_prev_product = {32'd0, mplier_q, 1'b0};
            RUN:     step_prev_product = step_product;
            default: step_prev_product = 65'd0;
        endcase
    end

    // The final step lands in step_product at the start of DONE, so the result is
    // forwarded combinationally during the ready cycle and held from then on.
    assign data_result       = (state == DONE) ? fin_result : result_q;
    assign data_exception    = (state == DONE) ? fin_exc : exc_q;
    assign data_resultRDY    = (state == DONE);
    assign busy              = (state != IDLE);
    assign step_multiplicand = mcand_q;

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Bench for mult_booth_ctrl: a Booth step unit model closes the loop, and a
// transaction-level model of latency and product arithmetic checks every cycle.
module tb_mult_booth_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [64:0] step_product = 65'd0;
    logic [64:0] step_prev_product;
    logic [31:0] step_multiplicand;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_booth_ctrl #(.N_STEPS(16)) dut (
        .clock(clk), .reset(rst), .ctrl_MULT(ctrl),
        .data_operandA(op_a), .data_operandB(op_b),
        .step_product(step_product), .step_prev_product(step_prev_product),
        .step_multiplicand(step_multiplicand), .data_result(data_result),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    // Registered radix-4 Booth step unit with a wrapping 32-bit upper adder.
    function automatic logic [64:0] booth_step(input logic [64:0] p, input logic [31:0] m);
        logic [31:0] addend;
        logic [31:0] acc;
        logic [64:0] q;
        case (p[2:0])
            3'b001, 3'b010: addend = m;
            3'b011:         addend = m << 1;
            3'b100:         addend = -(m << 1);
            3'b101, 3'b110: addend = -m;
            default:        addend = 32'd0;
        endcase
        acc = p[64:33] + addend;
        q = {acc, p[32:0]};
        return $signed(q) >>> 2;
    endfunction

    always @(posedge clk) step_product <= booth_step(step_prev_product, step_multiplicand);

    function automatic logic [31:0] prod_lo(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic logic prod_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: age = cycles since start (1 = load cycle, 17 = ready cycle).
    int          m_age = 0;
    logic [31:0] m_mcand = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [31:0] m_cur_res = 32'd0;
    logic        m_cur_exc = 1'b0;
    logic [31:0] m_held_res = 32'd0;
    logic        m_held_exc = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b1;
            m_age      <= 0;
            m_mcand    <= 32'd0;
            m_b        <= 32'd0;
            m_held_res <= 32'd0;
            m_held_exc <= 1'b0;
        end else begin
            if (m_age == 17) begin
                m_held_res <= m_cur_res;
                m_held_exc <= m_cur_exc;
            end
            if (ctrl) begin
                m_age     <= 1;
                m_mcand   <= op_a;
                m_b       <= op_b;
                m_cur_res <= prod_lo(op_a, op_b);
                m_cur_exc <= prod_ovf(op_a, op_b);
            end else if (m_age == 17) begin
                m_age <= 0;
            end else if (m_age > 0) begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 65'(busy), 65'(m_age != 0));
            chk("rdy", 65'(data_resultRDY), 65'(m_age == 17));
            chk("result", 65'(data_result), 65'((m_age == 17) ? m_cur_res : m_held_res));
            chk("exception", 65'(data_exception), 65'((m_age == 17) ? m_cur_exc : m_held_exc));
            chk("mcand", 65'(step_multiplicand), 65'(m_mcand));
            if (m_age == 1) chk("load_prev", step_prev_product, {32'd0, m_b, 1'b0});
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        ctrl = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        ctrl = 1'b0;
    endtask

    // Called in the load cycle; ready must appear on the 17th cycle counted from it.
    task automatic wait_rdy(input string name, input logic [31:0] exp_res, input logic exp_exc);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({name, "_latency"}, 65'(n), 65'(17));
        chk({name, "_res"}, 65'(data_result), 65'(exp_res));
        chk({name, "_exc"}, 65'(data_exception), 65'(exp_exc));
    endtask

    initial begin
        int rdy_seen;
        logic [31:0] a;
        logic [31:0] b;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_result", 65'(data_result), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_prev", step_prev_product, 65'd0);

        start(32'd3, 32'd5);
        chk("t1_busy_load", 65'(busy), 65'd1);
        wait_rdy("t1", 32'd15, 1'b0);
        start(32'hFFFF_FFF9, 32'd6);
        wait_rdy("t2", 32'hFFFF_FFD6, 1'b0);
        start(32'h0001_0000, 32'h0001_0000);
        wait_rdy("t3", 32'd0, 1'b1);
        start(32'd0, 32'h8000_0000);
        wait_rdy("t4a", 32'd0, 1'b0);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rdy("t4b", 32'd1, 1'b0);
        @(negedge clk);
        chk("t4b_hold", 65'(data_result), 65'd1);
        chk("t4b_idle", 65'(busy), 65'd0);

        start(32'd3, 32'd5);
        repeat (6) @(posedge clk);
        start(32'd4, 32'd4);
        wait_rdy("t5", 32'd16, 1'b0);

        start(32'd9, 32'd9);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", 65'(busy), 65'd0);
        chk("t6_result", 65'(data_result), 65'd0);
        chk("t6_mcand", 65'(step_multiplicand), 65'd0);
        rdy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("t6_no_rdy", 65'(rdy_seen), 65'd0);

        // Random ops with random gaps: covers aborts, back-to-back starts in the
        // ready cycle and idle stretches. Multiplicand magnitude kept below 2^29.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = 32'($urandom_range(0, 200)) - 32'd100;
                b = 32'($urandom_range(0, 200)) - 32'd100;
            end else begin
                a = 32'($urandom_range(0, 32'h3FFF_FFFF)) - 32'h2000_0000;
                b = $urandom;
            end
            start(a, b);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        repeat (25) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
